// File: rtl/multdiv_ctrl.sv
// Sequencing controller for iterative multiply/divide units.
// Latches operands, strobes a unit, counts iterations, captures result.
module multdiv_ctrl #(
  parameter int MULT_CYCLES = 16,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [31:0] mult_result,
  input  logic        mult_exception,
  input  logic [31:0] div_result,
  input  logic        div_exception,
  output logic [31:0] unit_operandA,
  output logic [31:0] unit_operandB,
  output logic        mult_start,
  output logic        div_start,
  output logic [5:0]  count,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  localparam logic [5:0] MC = 6'(MULT_CYCLES);
  localparam logic [5:0] DC = 6'(DIV_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_M,
    LOAD_D,
    RUN_M,
    RUN_D
  } state_t;

  state_t      r_state, w_state;
  logic [31:0] r_opa, w_opa;
  logic [31:0] r_opb, w_opb;
  logic [5:0]  r_count, w_count;
  logic [31:0] r_res, w_res;
  logic        r_exc, w_exc;
  logic        r_rdy, w_rdy;

  logic w_req;
  logic w_div0;

  assign w_req  = ctrl_DIV | ctrl_MULT;
  assign w_div0 = ctrl_DIV & (data_operandB == 32'd0);

  // Next state and datapath; a new request always preempts
  always_comb begin
    w_state = r_state;
    w_opa   = r_opa;
    w_opb   = r_opb;
    w_count = r_count;
    w_res   = r_res;
    w_exc   = r_exc;
    w_rdy   = 1'b0;
    if (w_req) begin
      w_opa   = data_operandA;
      w_opb   = data_operandB;
      w_count = 6'd0;
      if (w_div0) begin
        w_state = IDLE;
        w_res   = 32'd0;
        w_exc   = 1'b1;
        w_rdy   = 1'b1;
      end else if (ctrl_DIV) begin
        w_state = LOAD_D;
      end else begin
        w_state = LOAD_M;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state = IDLE;
        end
        LOAD_M: begin
          w_state = RUN_M;
          w_count = 6'd0;
        end
        LOAD_D: begin
          w_state = RUN_D;
          w_count = 6'd0;
        end
        RUN_M: begin
          if (r_count == MC) begin
            w_state = IDLE;
            w_count = 6'd0;
            w_res   = mult_result;
            w_exc   = mult_exception;
            w_rdy   = 1'b1;
          end else begin
            w_count = r_count + 6'd1;
          end
        end
        RUN_D: begin
          if (r_count == DC) begin
            w_state = IDLE;
            w_count = 6'd0;
            w_res   = div_result;
            w_exc   = div_exception;
            w_rdy   = 1'b1;
          end else begin
            w_count = r_count + 6'd1;
          end
        end
        default: begin
          w_state = IDLE;
          w_count = 6'd0;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_opa   <= 32'd0;
      r_opb   <= 32'd0;
      r_count <= 6'd0;
      r_res   <= 32'd0;
      r_exc   <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_opa   <= w_opa;
      r_opb   <= w_opb;
      r_count <= w_count;
      r_res   <= w_res;
      r_exc   <= w_exc;
      r_rdy   <= w_rdy;
    end
  end

  assign unit_operandA  = r_opa;
  assign unit_operandB  = r_opb;
  assign mult_start     = (r_state == LOAD_M);
  assign div_start      = (r_state == LOAD_D);
  assign count          = r_count;
  assign data_result    = r_res;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = (r_state != IDLE);

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 16, iteration edges the multiplier needs after its load edge; legal range 1..63.
REQ-002 Parameter DIV_CYCLES, default 32, iteration edges the divider needs after its load edge; legal range 1..63.
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low; reset==0 forces the reset state immediately.
REQ-005 ctrl_MULT  input  1  one-cycle multiply request, sampled on a rising edge.
REQ-006 ctrl_DIV  input  1  one-cycle divide request, sampled on a rising edge.
REQ-007 data_operandA  input  32  multiplicand/dividend; valid only in the request cycle.
REQ-008 data_operandB  input  32  multiplier/divisor; valid only in the request cycle.
REQ-009 mult_result  input  32  multiplier unit product.
REQ-010 mult_exception  input  1  multiplier unit overflow flag.
REQ-011 div_result  input  32  divider unit quotient.
REQ-012 div_exception  input  1  divider unit divide-by-zero flag.
REQ-013 unit_operandA  output  32  registered operand A, held stable for the whole operation.
REQ-014 unit_operandB  output  32  registered operand B, held stable for the whole operation.
REQ-015 mult_start  output  1  load strobe to the multiplier unit (its ctrl_MULT).
REQ-016 div_start  output  1  load strobe to the divider unit (its ctrl_DIV).
REQ-017 count  output  6  iteration counter shared by both units.
REQ-018 data_result  output  32  registered final result.
REQ-019 data_exception  output  1  registered final exception.
REQ-020 data_resultRDY  output  1  one-cycle completion pulse.
REQ-021 busy  output  1  high in any state other than IDLE.

Function
REQ-022 The block SHALL implement the states IDLE, LOAD_M, LOAD_D, RUN_M and RUN_D.
REQ-023 On an edge with ctrl_DIV=1, the block SHALL latch both operands into unit_operandA/B and go to LOAD_D; ctrl_DIV SHALL win when both requests are high.
REQ-024 On an edge with ctrl_MULT=1 and ctrl_DIV=0, the block SHALL latch both operands and go to LOAD_M.
REQ-025 A request accepted in any state, including RUN_* and the data_resultRDY cycle, SHALL abort the current operation; the aborted operation SHALL never produce data_resultRDY.
REQ-026 In LOAD_x, the matching x_start SHALL be 1 and count SHALL be 0; the next edge SHALL enter RUN_x with count=0.
REQ-027 In RUN_x, count SHALL increment by 1 per edge; both start strobes SHALL be 0.
REQ-028 In RUN_x, on the edge where count==X_CYCLES, the block SHALL capture x_result into data_result and x_exception into data_exception, set data_resultRDY=1 for exactly one cycle, clear count to 0 and return to IDLE.
REQ-029 Latency: data_resultRDY SHALL rise X_CYCLES+2 edges after the request edge (34 for default divide, 18 for default multiply).
REQ-030 Divide with data_operandB==0 at the request edge SHALL bypass LOAD_D/RUN_D: the next edge SHALL give data_result=0, data_exception=1 and data_resultRDY=1, with the state staying IDLE.
REQ-031 data_result and data_exception SHALL hold their values until the next capture; count SHALL never exceed 63.

Reset
REQ-032 While reset==0, the state SHALL be IDLE and count, unit_operandA/B, data_result, data_exception, data_resultRDY, busy, mult_start and div_start SHALL all be 0, including when reset is asserted mid-operation.
REQ-033 After reset is released, the first request SHALL be handled exactly as from power-up, with no stale data_resultRDY.

Verification
REQ-034 DIV 100 / -7 with the unit model -> data_resultRDY rises 34 edges after the request, data_result=-14 (0xFFFFFFF2), data_exception=0.
REQ-035 MULT 6 x -7 -> data_resultRDY rises 18 edges after the request, data_result=-42, data_exception=0.
REQ-036 DIV 5 / 0 -> next edge gives data_result=0, data_exception=1, data_resultRDY=1; busy stays 0.
REQ-037 DIV 100 / 7, then MULT 3 x 4 at count=10 -> no divide data_resultRDY; data_resultRDY rises 18 edges after the MULT request with data_result=12.
REQ-038 reset low at count=20 of a divide -> all outputs 0 immediately; after release, DIV 20 / 5 gives data_result=4 after 34 edges.
REQ-039 ctrl_MULT=ctrl_DIV=1 with operands 20 and 5 -> div_start pulses, mult_start stays 0, data_result=4.
